// File: rtl/compressed_fetch_queue.sv
// Fetch sequencer for the compressed decoder: one outstanding word read, halfword
// queue tagged with PC, redirect flush with discard of the in-flight response.
module compressed_fetch_queue #(
    parameter int          QueueDepth  = 4,
    parameter logic [31:0] ResetVector = 32'h0000_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRValid,
    input  logic [31:0] MemRData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        InstValid,
    output logic [15:0] Instruction,
    output logic [31:0] InstPC,
    input  logic        InstReady,
    output logic [1:0]  DebugState
);

    localparam int PtrW = $clog2(QueueDepth);
    localparam int CntW = PtrW + 1;
    localparam logic [CntW-1:0] FetchLimit = CntW'(QueueDepth - 2);
    localparam logic [CntW:0]   DepthLimit = (CntW + 1)'(QueueDepth);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } fetchState_t;

    fetchState_t     state, stateNext;
    logic [31:0]     fetchAddr, reqAddr, headPC;
    logic            skipLow, discard;
    logic [PtrW-1:0] rdPtr, wrPtr;
    logic [CntW-1:0] count, pushCount, countAfterPop;
    logic [CntW:0]   countSum;
    logic [15:0]     queueMem [QueueDepth];
    logic            pop, acceptData;
    logic            unusedPcBit;

    // Decode handshake: a head halfword transfers in any cycle where InstValid and
    // InstReady are both high; InstValid never depends on InstReady.
    assign pop           = InstValid & InstReady;
    assign acceptData    = MemRValid & ~discard & ~Redirect;
    assign pushCount     = acceptData ? (skipLow ? CntW'(1) : CntW'(2)) : '0;
    assign countAfterPop = count - CntW'(pop);
    assign countSum      = {1'b0, count} + {1'b0, pushCount} - (CntW + 1)'(pop);
    assign unusedPcBit   = RedirectPC[0];

    assign InstValid   = (count != '0);
    assign Instruction = queueMem[rdPtr];
    assign InstPC      = headPC;
    assign MemAddr     = reqAddr;
    assign DebugState  = state;

    always_comb begin
        stateNext = state;
        MemReq    = 1'b0;
        case (state)
            StIdle: if (countAfterPop <= FetchLimit && !Redirect) stateNext = StReq;
            StReq: begin
                MemReq = 1'b1;
                if (MemGnt) stateNext = StWait;
            end
            StWait: if (MemRValid) stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= StIdle;
            fetchAddr <= {ResetVector[31:2], 2'b00};
            reqAddr   <= {ResetVector[31:2], 2'b00};
            headPC    <= {ResetVector[31:1], 1'b0};
            skipLow   <= ResetVector[1];
            discard   <= 1'b0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            count     <= '0;
        end else begin
            state <= stateNext;
            // The request address is latched once so it stays put even if a redirect lands mid-request.
            if (state == StIdle && stateNext == StReq) reqAddr <= fetchAddr;
            if (Redirect) begin
                fetchAddr <= {RedirectPC[31:2], 2'b00};
                headPC    <= {RedirectPC[31:1], 1'b0};
                skipLow   <= RedirectPC[1];
                rdPtr     <= '0;
                wrPtr     <= '0;
                count     <= '0;
                discard   <= (state == StReq) || (state == StWait && !MemRValid);
            end else begin
                // A discarded request already had fetchAddr retargeted by its redirect.
                if (state == StReq && MemGnt && !discard) fetchAddr <= fetchAddr + 32'd4;
                if (acceptData) begin
                    skipLow <= 1'b0;
                    wrPtr   <= wrPtr + pushCount[PtrW-1:0];
                end
                if (MemRValid) discard <= 1'b0;
                if (pop) begin
                    rdPtr  <= rdPtr + PtrW'(1);
                    headPC <= headPC + 32'd2;
                end
                count <= count + pushCount - CntW'(pop);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (acceptData) begin
            if (skipLow) begin
                queueMem[wrPtr] <= MemRData[31:16];
            end else begin
                queueMem[wrPtr]              <= MemRData[15:0];
                queueMem[wrPtr + PtrW'(1)]   <= MemRData[31:16];
            end
        end
    end

    assert property (@(posedge Clock) disable iff (Reset) Redirect || (countSum <= DepthLimit));

endmodule
